gate_unit_arbiter: RTL
======================

Name: gate_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (AND, OR, NOT, XOR) among NREQ requesters.
- Each requester uses a valid/ready request port. Requests are granted round-robin and computed one at a time. The result goes out on a single response port tagged with the requester ID.
- Sits between the gate-level datapath and any clients that issue bitwise operations.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, operand/result width in bits
- CNT_W, 16, width of the completed-operation counter

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_op  input  2*NREQ  per-requester opcode; slice i = [2i+1:2i]
- req_a  input  WIDTH*NREQ  per-requester operand A
- req_b  input  WIDTH*NREQ  per-requester operand B; ignored for NOT
- req_ready  output  NREQ  one-hot accept strobe
- rsp_valid  output  1  result valid
- rsp_id  output  $clog2(NREQ)  index of the requester that owns the result
- rsp_y  output  WIDTH  result
- rsp_ready  input  1  consumer accepts the result
- busy  output  1  high while not IDLE
- op_count  output  CNT_W  number of responses consumed, saturating

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, rr_ptr=NREQ-1, so requester 0 has first priority.
  - rsp_valid=0, rsp_id=0, rsp_y=0, busy=0, op_count=0, req_ready=0.
- Opcodes: 00 AND (a&b), 01 OR (a|b), 10 NOT (~a), 11 XOR (a^b). All operations are bitwise on WIDTH bits.
- Arbitration:
  - Search starts at rr_ptr+1 modulo NREQ; the first index with req_valid=1 wins.
  - rr_ptr updates to the winner on accept only.
- Accept condition: (state==IDLE) or (state==RESP and rsp_ready==1), and at least one req_valid.
  - req_ready[winner]=1 combinationally in that cycle; all other ready bits are 0.
  - op, a and b are registered on that edge.
- Requester rule: valid/op/a/b are held stable until ready. A requester may drop valid without having been accepted.
- FSM:
  - IDLE: accept -> EXEC; otherwise stay.
  - EXEC: one cycle. Compute from captured operands; load rsp_y and rsp_id; -> RESP. No accept in EXEC.
  - RESP: rsp_valid=1; rsp_y and rsp_id are held stable until rsp_ready.
    - rsp_ready with a pending accept -> EXEC (back-to-back).
    - rsp_ready without a pending accept -> IDLE.
    - No rsp_ready -> stay.
- Latency: accept at edge N; rsp_valid rises after edge N+1; earliest consume at edge N+2. Peak throughput is 1 result per 2 cycles.
- rsp_valid is registered; it is 0 in IDLE and EXEC.
- op_count increments on rsp_valid & rsp_ready and saturates at 2^CNT_W-1 (no wrap).
- rr_ptr wraps from NREQ-1 to 0.
- A single valid requester is re-granted every opportunity; no starvation of itself.
- Reset mid-operation: the in-flight result is discarded and no response is emitted. Requesters must re-issue.
- An illegal rsp_ready while not in RESP is ignored.

Decomposition:
- Shared package gate_unit_pkg:
  - opcode localparams OP_AND=2'b00, OP_OR=2'b01, OP_NOT=2'b10, OP_XOR=2'b11
  - state encoding IDLE/EXEC/RESP
- One sub-module, rr_arbiter:
  - Parameter NREQ.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, grant index, any_grant.
  - Purely combinational. rr_ptr storage stays in the top module.
- The logic function lives in the top module as a case on the registered opcode.

Test Plan:
- Single op: req0 valid, op=00, a=8'hF0, b=8'h3C, rsp_ready=1 -> req_ready[0] pulses once; two cycles later rsp_valid=1, rsp_id=0, rsp_y=8'h30; op_count=1.
- All opcodes via req2: a=8'hA5, b=8'h0F -> AND 8'h05, OR 8'hAF, NOT 8'h5A, XOR 8'hAA, each with rsp_id=2.
- Round-robin: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1; one response every 2 cycles; no requester is granted twice before the others.
- Backpressure: rsp_ready=0 for 5 cycles while req1/req3 are valid -> rsp_y and rsp_id stay stable and no req_ready pulses. On rsp_ready=1, the next grant fires in the same cycle.
- Reset mid-op: assert rst_n=0 during EXEC -> rsp_valid stays 0, busy=0, op_count=0. After release, requester 0 has first priority.
- Saturation, with CNT_W=3: 9 consumed responses -> op_count holds at 7.

Source files
------------

// File: rtl/gate_unit_pkg.sv
// Shared definitions for the bitwise logic unit arbiter: opcodes and FSM states.
package gate_unit_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_NOT = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past rr_ptr_i and wraps.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] rr_ptr_i,
  input  logic                    enable_i,
  output logic [NREQ-1:0]         grant_o,
  output logic [$clog2(NREQ)-1:0] grant_idx_o,
  output logic                    any_grant_o
);

  localparam int IDW = $clog2(NREQ);

  // Walk the requesters in priority order and take the first active one.
  always_comb begin
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_i) + k) % NREQ;
      if (enable_i && !found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDW'(idx);
        found        = 1'b1;
      end
    end
    any_grant_o = found;
  end

endmodule

// File: rtl/gate_unit_arbiter.sv
// One shared bitwise logic unit serving NREQ valid/ready requesters in round-robin order.
module gate_unit_arbiter
  import gate_unit_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rsp_valid,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_y,
  input  logic                    rsp_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_count
);

  localparam int IDW = $clog2(NREQ);

  state_e           state_q;
  logic [IDW-1:0]   rr_ptr_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_y_q;
  logic [CNT_W-1:0] op_count_q;

  logic             accept_en;
  logic             accept;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [WIDTH-1:0] y_d;

  // The unit can take a new operation when idle, or when the held result leaves this cycle.
  assign accept_en = rst_n && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready));

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .req_i      (req_valid),
    .rr_ptr_i   (rr_ptr_q),
    .enable_i   (accept_en),
    .grant_o    (grant),
    .grant_idx_o(grant_idx),
    .any_grant_o(accept)
  );

  // Bitwise function of the captured operands; b is don't-care for NOT.
  always_comb begin
    y_d = '0;
    case (op_q)
      OP_AND:  y_d = a_q & b_q;
      OP_OR:   y_d = a_q | b_q;
      OP_NOT:  y_d = ~a_q;
      OP_XOR:  y_d = a_q ^ b_q;
      default: y_d = '0;
    endcase
  end

  // Control FSM with operand capture and registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= IDW'(NREQ - 1);
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= '0;
    end else begin
      if (accept) begin
        // rr_ptr_q doubles as the owner id of the operation in flight.
        rr_ptr_q <= grant_idx;
        op_q     <= req_op[2*int'(grant_idx) +: 2];
        a_q      <= req_a[WIDTH*int'(grant_idx) +: WIDTH];
        b_q      <= req_b[WIDTH*int'(grant_idx) +: WIDTH];
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          rsp_y_q     <= y_d;
          rsp_id_q    <= rr_ptr_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= accept ? ST_EXEC : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Saturating count of consumed responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (rsp_valid_q && rsp_ready && (op_count_q != {CNT_W{1'b1}})) begin
      op_count_q <= op_count_q + 1'b1;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign busy      = (state_q != ST_IDLE);
  assign op_count  = op_count_q;

endmodule
